sensor_collect_unit: RTL and testbench

//  Sensor-side stage directly upstream of the sync unit. On each SYNC_IN pulse it polls every sensor in

---
 rtl/sensor_collect_unit_pkg.sv | 16 +
 rtl/sensor_collect_unit_req_timer.sv | 34 +++
 rtl/sensor_collect_unit.sv | 149 ++++++++++++++
 tb/tb_sensor_collect_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_collect_unit_pkg.sv
// Shared types for the sensor collection stage: FSM encoding and timer sizing.
package sensor_collect_unit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int unsigned timer_width(input int unsigned value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/sensor_collect_unit_req_timer.sv
// Per-request wait counter; tc_o flags the last permitted cycle without an ACK.
module sensor_collect_unit_req_timer #(
  parameter int unsigned Limit = 16,
  parameter int unsigned Width = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == Width'(Limit - 1));

endmodule

// File: rtl/sensor_collect_unit.sv
// Polls each sensor on SYNC_IN, writes samples to sensor memory and flags completion.
module sensor_collect_unit
  import sensor_collect_unit_pkg::*;
#(
  parameter int unsigned SENSOR_COUNT    = 4,
  parameter int unsigned SENSOR_ID_WIDTH = 2,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MEM_ADDR_WIDTH  = 8,
  parameter int unsigned BASE_ADDR       = 0,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic                       CGRA_CLK_I,
  input  logic                       RST_N_I,
  input  logic                       EN_I,
  input  logic                       SYNC_IN_I,
  input  logic                       RUN_STARTED_I,
  input  logic                       ERR_CLR_I,
  output logic                       SENSOR_REQ_O,
  output logic [SENSOR_ID_WIDTH-1:0] SENSOR_ID_O,
  input  logic                       SENSOR_ACK_I,
  input  logic [DATA_WIDTH-1:0]      SENSOR_DATA_I,
  output logic                       MEM_WR_EN_O,
  output logic [MEM_ADDR_WIDTH-1:0]  MEM_WR_ADDR_O,
  output logic [DATA_WIDTH-1:0]      MEM_WR_DATA_O,
  output logic                       SENSOR_WRITES_COMPLETE_O,
  output logic                       TIMEOUT_ERR_O,
  output logic                       OVERRUN_ERR_O
);

  localparam logic [SENSOR_ID_WIDTH-1:0] LastIdx = SENSOR_ID_WIDTH'(SENSOR_COUNT - 1);

  state_e                     state_q, state_d;
  logic [SENSOR_ID_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic                       complete_q;
  logic                       tmo_err_q, tmo_err_d, tmo_set;
  logic                       ovr_err_q, ovr_err_d, ovr_set;
  logic                       tmr_clr, tmr_inc, tmr_tc;

  if (TIMEOUT_CYCLES > 0) begin : g_timer
    sensor_collect_unit_req_timer #(
      .Limit(TIMEOUT_CYCLES),
      .Width(timer_width(TIMEOUT_CYCLES + 1))
    ) u_req_timer (
      .clk_i (CGRA_CLK_I),
      .rst_ni(RST_N_I),
      .clr_i (tmr_clr),
      .inc_i (tmr_inc),
      .tc_o  (tmr_tc)
    );
  end else begin : g_no_timer
    logic unused_tmr;
    assign unused_tmr = tmr_clr ^ tmr_inc;
    assign tmr_tc     = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    tmo_set = 1'b0;
    ovr_set = 1'b0;
    if (EN_I) begin
      unique case (state_q)
        StIdle: begin
          if (SYNC_IN_I) begin
            state_d = StReq;
            idx_d   = '0;
            tmr_clr = 1'b1;
          end
        end
        StReq: begin
          ovr_set = SYNC_IN_I;
          if (SENSOR_ACK_I) begin
            wdata_d = SENSOR_DATA_I;
            state_d = StWrite;
          end else if (tmr_tc) begin
            // Skip the silent sensor; its memory slot keeps the old sample.
            tmo_set = 1'b1;
            tmr_clr = 1'b1;
            if (idx_q == LastIdx) begin
              state_d = StDone;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            tmr_inc = 1'b1;
          end
        end
        StWrite: begin
          ovr_set = SYNC_IN_I;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StReq;
            tmr_clr = 1'b1;
          end
        end
        StDone: begin
          if (RUN_STARTED_I) begin
            state_d = StIdle;
            idx_d   = '0;
          end else if (SYNC_IN_I) begin
            state_d = StReq;
            idx_d   = '0;
            tmr_clr = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A new error in the same cycle as a clear keeps the flag set.
  assign tmo_err_d = tmo_set | (tmo_err_q & ~(EN_I & ERR_CLR_I));
  assign ovr_err_d = ovr_set | (ovr_err_q & ~(EN_I & ERR_CLR_I));

  always_ff @(posedge CGRA_CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      wdata_q    <= '0;
      complete_q <= 1'b0;
      tmo_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      complete_q <= (state_d == StDone);
      tmo_err_q  <= tmo_err_d;
      ovr_err_q  <= ovr_err_d;
    end
  end

  assign SENSOR_REQ_O             = (state_q == StReq);
  assign SENSOR_ID_O              = idx_q;
  assign MEM_WR_EN_O              = (state_q == StWrite) & EN_I;
  assign MEM_WR_ADDR_O            = (state_q == StWrite) ?
                                    MEM_ADDR_WIDTH'(BASE_ADDR + 32'(idx_q)) : '0;
  assign MEM_WR_DATA_O            = wdata_q;
  assign SENSOR_WRITES_COMPLETE_O = complete_q;
  assign TIMEOUT_ERR_O            = tmo_err_q;
  assign OVERRUN_ERR_O            = ovr_err_q;

endmodule

// File: tb/tb_sensor_collect_unit.sv
// Directed bench: sensor responder and memory model around sensor_collect_unit.
module tb_sensor_collect_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        sync_in = 1'b0;
  logic        run_started = 1'b0;
  logic        err_clr = 1'b0;
  logic        req;
  logic [1:0]  id;
  logic        ack;
  logic [31:0] sdata;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        complete;
  logic        tmo_err;
  logic        ovr_err;

  logic [3:0]  mute = 4'b0000;
  logic [31:0] data_base = 32'hA0;
  logic [31:0] mem [0:255];
  int          wr_cnt [0:255];
  int          base_cnt [0:3];
  int          n_chk = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  sensor_collect_unit #(
    .SENSOR_COUNT   (4),
    .SENSOR_ID_WIDTH(2),
    .DATA_WIDTH     (32),
    .MEM_ADDR_WIDTH (8),
    .BASE_ADDR      (0),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CGRA_CLK_I              (clk),
    .RST_N_I                 (rst_n),
    .EN_I                    (en),
    .SYNC_IN_I               (sync_in),
    .RUN_STARTED_I           (run_started),
    .ERR_CLR_I               (err_clr),
    .SENSOR_REQ_O            (req),
    .SENSOR_ID_O             (id),
    .SENSOR_ACK_I            (ack),
    .SENSOR_DATA_I           (sdata),
    .MEM_WR_EN_O             (wr_en),
    .MEM_WR_ADDR_O           (wr_addr),
    .MEM_WR_DATA_O           (wr_data),
    .SENSOR_WRITES_COMPLETE_O(complete),
    .TIMEOUT_ERR_O           (tmo_err),
    .OVERRUN_ERR_O           (ovr_err)
  );

  // Sensors answer in the same cycle they see REQ unless muted.
  always_comb begin
    ack   = req & ~mute[id];
    sdata = data_base + 32'(id);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'h0;
      wr_cnt[i] = 0;
    end
  end

  always @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr]    <= wr_data;
      wr_cnt[wr_addr] <= wr_cnt[wr_addr] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sync();
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
  endtask

  task automatic pulse_run();
    run_started = 1'b1;
    tick();
    run_started = 1'b0;
  endtask

  task automatic snap();
    for (int i = 0; i < 4; i++) base_cnt[i] = wr_cnt[i];
  endtask

  // Step until COMPLETE or budget runs out; also counts REQ cycles spent on sensor 2.
  task automatic run_to_done(output int edges, output int req2);
    edges = 0;
    req2  = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      edges++;
      if (req && id == 2'd2) req2++;
      if (complete) break;
    end
  endtask

  task automatic chk_sweep(input string tag, input logic [31:0] base, input logic [3:0] skip);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_cnt%0d", tag, i), 64'(wr_cnt[i] - base_cnt[i]), skip[i] ? 64'd0 : 64'd1);
      if (!skip[i]) chk($sformatf("%s_mem%0d", tag, i), 64'(mem[i]), 64'(base + 32'(i)));
    end
  endtask

  initial begin
    int edges;
    int req2;

    #3;
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_id", 64'(id), 64'd0);
    chk("rst_wr", 64'(wr_en), 64'd0);
    chk("rst_cmp", 64'(complete), 64'd0);
    chk("rst_errs", 64'({tmo_err, ovr_err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: full sweep with immediate ACK; COMPLETE is first seen after the 9th edge
    //    counting the SYNC-sampling edge as the 1st.
    snap();
    data_base = 32'hA0;
    pulse_sync();
    chk("t1_req0", 64'({req, id}), 64'({1'b1, 2'd0}));
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 1) chk("t1_wr0", 64'({wr_en, wr_addr}), 64'({1'b1, 8'd0}));
      if (n == 7) chk("t1_cmp_early", 64'(complete), 64'd0);
      if (n == 8) chk("t1_cmp", 64'(complete), 64'd1);
    end
    chk_sweep("t1", 32'hA0, 4'b0000);
    pulse_run();
    chk("t1_cmp_drop", 64'(complete), 64'd0);

    // 2: sensor 2 silent -> skipped after 16 REQ cycles.
    snap();
    data_base = 32'hB0;
    mute      = 4'b0100;
    pulse_sync();
    run_to_done(edges, req2);
    chk("t2_req2_cycles", 64'(req2), 64'd16);
    chk("t2_cmp", 64'(complete), 64'd1);
    chk("t2_tmo", 64'(tmo_err), 64'd1);
    chk("t2_ovr", 64'(ovr_err), 64'd0);
    chk_sweep("t2", 32'hB0, 4'b0100);
    chk("t2_mem2_kept", 64'(mem[2]), 64'hA2);
    mute    = 4'b0000;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t2_tmo_clr", 64'(tmo_err), 64'd0);
    pulse_run();

    // 3: SYNC during REQ of sensor 1 -> overrun, sweep unchanged.
    snap();
    data_base = 32'hC0;
    pulse_sync();
    tick();
    tick();
    chk("t3_req1", 64'({req, id}), 64'({1'b1, 2'd1}));
    pulse_sync();
    chk("t3_ovr", 64'(ovr_err), 64'd1);
    run_to_done(edges, req2);
    chk("t3_edges", 64'(edges + 3), 64'd8);
    chk_sweep("t3", 32'hC0, 4'b0000);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_ovr_clr", 64'(ovr_err), 64'd0);

    // 4: RUN_STARTED and SYNC together in DONE -> IDLE; then SYNC alone in DONE restarts.
    run_started = 1'b1;
    sync_in     = 1'b1;
    tick();
    run_started = 1'b0;
    sync_in     = 1'b0;
    chk("t4_cmp", 64'(complete), 64'd0);
    tick();
    chk("t4_idle", 64'(req), 64'd0);
    pulse_sync();
    run_to_done(edges, req2);
    chk("t4_done1", 64'(complete), 64'd1);
    snap();
    data_base = 32'hD0;
    pulse_sync();
    chk("t4_restart", 64'({complete, req, id}), 64'({1'b0, 1'b1, 2'd0}));
    run_to_done(edges, req2);
    chk("t4_ovr", 64'(ovr_err), 64'd0);
    chk_sweep("t4", 32'hD0, 4'b0000);
    pulse_run();

    // 5: EN low for 5 cycles while in WRITE of sensor 0.
    snap();
    data_base = 32'hE0;
    pulse_sync();
    tick();
    en = 1'b0;
    #1;
    chk("t5_gate", 64'(wr_en), 64'd0);
    for (int n = 0; n < 5; n++) begin
      tick();
      if (wr_en) chk("t5_paused_wr", 64'(wr_en), 64'd0);
    end
    chk("t5_held_cmp", 64'(complete), 64'd0);
    en = 1'b1;
    #1;
    chk("t5_resume", 64'({wr_en, wr_addr}), 64'({1'b1, 8'd0}));
    run_to_done(edges, req2);
    chk_sweep("t5", 32'hE0, 4'b0000);
    pulse_run();

    // 6: async reset during REQ of sensor 3 with an overrun pending.
    snap();
    data_base = 32'hF0;
    pulse_sync();
    pulse_sync();
    for (int n = 0; n < 5; n++) tick();
    chk("t6_req3", 64'({req, id, ovr_err}), 64'({1'b1, 2'd3, 1'b1}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out", 64'({req, id, wr_en, complete, tmo_err, ovr_err}), 64'd0);
    chk("t6_rst_bus", 64'({wr_addr, wr_data}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) tick();
    chk("t6_idle", 64'({req, complete}), 64'd0);
    chk("t6_no_wr3", 64'(wr_cnt[3] - base_cnt[3]), 64'd0);
    pulse_sync();
    chk("t6_after", 64'({req, id}), 64'({1'b1, 2'd0}));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
